// File: rtl/cmp_arb_pkg.sv
// Shared types and defaults for the comparator arbiter (cmp_arbiter, rr_pick).
// Build option CMP_ARB_FIXED_PRIO_EN is consumed by cmp_arbiter, not here.
package cmp_arb_pkg;

   localparam int CMP_W     = 8;
   localparam int CMP_N_REQ = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   typedef struct packed {
      logic eq;
      logic gt;
      logic lt;
   } cmp_res_t;

   // A healthy comparator raises exactly one of its three flags.
   function automatic logic res_not_onehot(input cmp_res_t r);
      return !((r.eq ^ r.gt ^ r.lt) && !(r.eq && r.gt && r.lt));
   endfunction

endpackage

// File: rtl/cmp_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from ptr,
// wrapping at N-1. With ptr tied to 0 it degenerates to lowest-index priority.
module rr_pick #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         win,
   output logic [$clog2(N)-1:0] idx,
   output logic                 any
);

   localparam int PW = $clog2(N);

   logic [PW-1:0] cand;

   always_comb begin
      win  = '0;
      idx  = '0;
      any  = 1'b0;
      cand = '0;
      for (int k = 0; k < N; k++) begin
         cand = PW'((int'(ptr) + k) % N);
         if (!any && req[cand]) begin
            any       = 1'b1;
            idx       = cand;
            win[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cmp_arbiter.sv
// Shares one magnitude comparator between N_REQ requesters (grant/wait/respond).
// Define CMP_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module cmp_arbiter
   import cmp_arb_pkg::*;
#(
   parameter int N_REQ   = CMP_N_REQ,
   parameter int W       = CMP_W,
   parameter int CMP_LAT = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req,
   input  logic [N_REQ*W-1:0] a_in,
   input  logic [N_REQ*W-1:0] b_in,
   output logic [N_REQ-1:0]   gnt,
   output logic [N_REQ-1:0]   done,
   output logic               res_eq,
   output logic               res_gt,
   output logic               res_lt,
   output logic               res_err,
   output logic               busy,
   output logic [W-1:0]       cmp_a,
   output logic [W-1:0]       cmp_b,
   input  logic               cmp_eq,
   input  logic               cmp_gt,
   input  logic               cmp_lt
);

   localparam int PW = $clog2(N_REQ);
   localparam int CW = $clog2(CMP_LAT + 1);

   state_t           state;
   logic [PW-1:0]    win_idx;
   logic [N_REQ-1:0] win_oh;
   logic [CW-1:0]    cnt;
   logic [PW-1:0]    ptr;
   logic [N_REQ-1:0] pick_oh;
   logic [PW-1:0]    pick_idx;
   logic             pick_any;
   logic [W-1:0]     sel_a;
   logic [W-1:0]     sel_b;
   cmp_res_t         sampled;

`ifdef CMP_ARB_FIXED_PRIO_EN
   assign ptr = '0;
`endif

   rr_pick #(.N(N_REQ)) u_pick (
      .req (req),
      .ptr (ptr),
      .win (pick_oh),
      .idx (pick_idx),
      .any (pick_any)
   );

   // Operand mux driven by the one-hot winner so slice indices stay constant.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (pick_oh[k]) begin
            sel_a = a_in[k*W +: W];
            sel_b = b_in[k*W +: W];
         end
      end
   end

   assign sampled = {cmp_eq, cmp_gt, cmp_lt};

   // Flags are captured on the edge that enters RESP so done and res_* rise together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         gnt     <= '0;
         done    <= '0;
         res_eq  <= 1'b0;
         res_gt  <= 1'b0;
         res_lt  <= 1'b0;
         res_err <= 1'b0;
         busy    <= 1'b0;
         cmp_a   <= '0;
         cmp_b   <= '0;
         win_idx <= '0;
         win_oh  <= '0;
         cnt     <= '0;
`ifndef CMP_ARB_FIXED_PRIO_EN
         ptr     <= '0;
`endif
      end else begin
         gnt  <= '0;
         done <= '0;
         case (state)
            IDLE: begin
               if (pick_any) begin
                  win_idx <= pick_idx;
                  win_oh  <= pick_oh;
                  gnt     <= pick_oh;
                  cmp_a   <= sel_a;
                  cmp_b   <= sel_b;
                  busy    <= 1'b1;
                  state   <= GRANT;
               end
            end
            GRANT: begin
               cnt   <= CW'(CMP_LAT - 1);
               state <= WAIT;
            end
            WAIT: begin
               if (cnt == '0) begin
                  done    <= win_oh;
                  res_eq  <= sampled.eq;
                  res_gt  <= sampled.gt;
                  res_lt  <= sampled.lt;
                  res_err <= res_not_onehot(sampled);
`ifndef CMP_ARB_FIXED_PRIO_EN
                  ptr     <= (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
`endif
                  state   <= RESP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cmp_arbiter.sv
// Self-checking bench for cmp_arbiter: transaction-level model plus directed cases.
// Honours CMP_ARB_FIXED_PRIO_EN when the design is built with it.
module tb_cmp_arbiter;

   localparam int N   = 4;
   localparam int W   = 8;
   localparam int LAT = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst;
   logic [N-1:0]   req;
   logic [N*W-1:0] a_in, b_in;
   logic [N-1:0]   gnt, done;
   logic           res_eq, res_gt, res_lt, res_err, busy;
   logic [W-1:0]   cmp_a, cmp_b;
   logic           c_eq, c_gt, c_lt;
   logic           fault;
   logic           auto_drop;

   logic [N-1:0]   req3;
   logic [N*W-1:0] a3, b3;
   logic [N-1:0]   gnt3, done3;
   logic           res_eq3, res_gt3, res_lt3, res_err3, busy3;
   logic [W-1:0]   cmp_a3, cmp_b3;
   logic           c_eq3, c_gt3, c_lt3;
   logic           fault3;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   // Behavioural comparators; a fault forces the "larger" flag on.
   assign c_eq  = (cmp_a == cmp_b);
   assign c_gt  = (cmp_a > cmp_b) | fault;
   assign c_lt  = (cmp_a < cmp_b);
   assign c_eq3 = (cmp_a3 == cmp_b3);
   assign c_gt3 = (cmp_a3 > cmp_b3) | fault3;
   assign c_lt3 = (cmp_a3 < cmp_b3);

   cmp_arbiter #(.N_REQ(N), .W(W), .CMP_LAT(LAT)) dut (
      .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
      .gnt(gnt), .done(done), .res_eq(res_eq), .res_gt(res_gt), .res_lt(res_lt),
      .res_err(res_err), .busy(busy), .cmp_a(cmp_a), .cmp_b(cmp_b),
      .cmp_eq(c_eq), .cmp_gt(c_gt), .cmp_lt(c_lt)
   );

   cmp_arbiter #(.N_REQ(N), .W(W), .CMP_LAT(3)) dut3 (
      .clk(clk), .rst(rst), .req(req3), .a_in(a3), .b_in(b3),
      .gnt(gnt3), .done(done3), .res_eq(res_eq3), .res_gt(res_gt3), .res_lt(res_lt3),
      .res_err(res_err3), .busy(busy3), .cmp_a(cmp_a3), .cmp_b(cmp_b3),
      .cmp_eq(c_eq3), .cmp_gt(c_gt3), .cmp_lt(c_lt3)
   );

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Requesters drop their request in the cycle after seeing their grant.
   always @(posedge clk) begin
      logic [N-1:0] g;
      g = gnt;
      #1;
      if (auto_drop) req = req & ~g;
   end

   // Transaction model: a grant starts a fixed-length transaction timed by its age.
   bit           m_valid = 0;
   bit           m_active = 0;
   int           m_age = 0, m_w = 0, m_ptr = 0;
   logic [W-1:0] m_a, m_b;
   logic [N-1:0] e_gnt = '0, e_done = '0;
   logic         e_eq = 0, e_gt = 0, e_lt = 0, e_err = 0, e_busy = 0;
   logic [W-1:0] e_ca = '0, e_cb = '0;

   always @(posedge clk) begin
      if (rst) begin
         m_valid = 1; m_active = 0; m_ptr = 0;
         e_gnt = '0; e_done = '0; e_eq = 0; e_gt = 0; e_lt = 0; e_err = 0; e_busy = 0;
         e_ca = '0; e_cb = '0;
      end else if (m_valid) begin
         e_gnt = '0;
         if (!m_active) begin
            if (req != '0) begin
               m_w = -1;
               for (int k = 0; k < N; k++) begin
                  int j;
                  j = (m_ptr + k) % N;
                  if (m_w < 0 && req[j]) m_w = j;
               end
               m_a = W'(a_in >> (m_w * W));
               m_b = W'(b_in >> (m_w * W));
               m_active = 1; m_age = 0;
               e_gnt = N'(1 << m_w);
               e_busy = 1; e_ca = m_a; e_cb = m_b;
            end
         end else begin
            m_age++;
            e_done = '0;
            if (m_age == LAT + 1) begin
               e_done = N'(1 << m_w);
               e_eq = (m_a == m_b);
               e_gt = (m_a > m_b) | fault;
               e_lt = (m_a < m_b);
               e_err = (int'(e_eq) + int'(e_gt) + int'(e_lt)) != 1;
`ifndef CMP_ARB_FIXED_PRIO_EN
               m_ptr = (m_w + 1) % N;
`endif
            end else if (m_age == LAT + 2) begin
               m_active = 0; e_busy = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (m_valid)
         check_output("cycle_outputs",
            {gnt, done, res_eq, res_gt, res_lt, res_err, busy, cmp_a, cmp_b},
            {e_gnt, e_done, e_eq, e_gt, e_lt, e_err, e_busy, e_ca, e_cb});
   end

   // Event log for the directed checks.
   int       gnt_who[$], gnt_t[$], done_t[$];
   logic [3:0] done_res[$];
   logic [N-1:0] done_who[$];

   always @(negedge clk) begin
      if (gnt != '0) begin
         for (int k = 0; k < N; k++) if (gnt[k]) gnt_who.push_back(k);
         gnt_t.push_back(cyc);
      end
      if (done != '0) begin
         done_t.push_back(cyc);
         done_res.push_back({res_eq, res_gt, res_lt, res_err});
         done_who.push_back(done);
      end
   end

   task automatic clear_logs();
      gnt_who.delete(); gnt_t.delete(); done_t.delete(); done_res.delete(); done_who.delete();
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic apply_stimulus(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
      a_in[idx*W +: W] = a;
      b_in[idx*W +: W] = b;
      req[idx] = 1'b1;
   endtask

   task automatic wait_dones(input int n);
      int t;
      t = 0;
      while (done_t.size() < n && t < 200) begin
         @(negedge clk);
         t++;
      end
      check_output("done_within_budget", 64'(done_t.size() >= n), 64'd1);
      tick();
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   int c0;
   int exp_a [2];
   int exp_h [3];

   initial begin
      rst = 1'b1; req = '0; a_in = '0; b_in = '0; fault = 0; auto_drop = 1;
      req3 = '0; a3 = '0; b3 = '0; fault3 = 0;
      tick(); tick(); tick();
      check_output("reset_busy", 64'(busy), 64'd0);
      check_output("reset_gnt_done", 64'({gnt, done}), 64'd0);
      check_output("reset_cmp_ops", 64'({cmp_a, cmp_b}), 64'd0);
      rst = 1'b0;
      tick();

      // Single request, A > B.
      clear_logs();
      c0 = cyc;
      apply_stimulus(0, 8'h10, 8'h08);
      wait_dones(1);
      check_output("single_gnt_cycle", 64'(gnt_t[0] - c0), 64'd1);
      check_output("single_gnt_who", 64'(gnt_who[0]), 64'd0);
      check_output("single_done_cycle", 64'(done_t[0] - c0), 64'd3);
      check_output("single_done_who", 64'(done_who[0]), 64'b0001);
      check_output("single_res_gt", 64'(done_res[0]), 64'b0100);

      // Requester 2: smaller, then equal.
      clear_logs();
      apply_stimulus(2, 8'h10, 8'h20);
      wait_dones(1);
      check_output("lt_res", 64'(done_res[0]), 64'b0010);
      check_output("lt_done_who", 64'(done_who[0]), 64'b0100);
      clear_logs();
      apply_stimulus(2, 8'h10, 8'h10);
      wait_dones(1);
      check_output("eq_res", 64'(done_res[0]), 64'b1000);
      check_output("eq_done_who", 64'(done_who[0]), 64'b0100);

      // All four request at once from pointer 0.
      reset_dut();
      clear_logs();
      for (int i = 0; i < N; i++) apply_stimulus(i, 8'(8'h20 + i), 8'h21);
      wait_dones(4);
      for (int i = 0; i < N; i++) check_output($sformatf("rr4_order_%0d", i), 64'(gnt_who[i]), 64'(i));
      check_output("rr4_spacing", 64'(gnt_t[2] - gnt_t[1]), 64'd4);

      // Winner 1 moves the pointer to 2, then 0101 is requested.
      clear_logs();
      apply_stimulus(1, 8'h01, 8'h02);
      wait_dones(1);
      clear_logs();
      apply_stimulus(0, 8'h33, 8'h44);
      apply_stimulus(2, 8'h55, 8'h44);
`ifdef CMP_ARB_FIXED_PRIO_EN
      exp_a = '{0, 2};
`else
      exp_a = '{2, 0};
`endif
      wait_dones(2);
      check_output("rr_ptr2_first", 64'(gnt_who[0]), 64'(exp_a[0]));
      check_output("rr_ptr2_second", 64'(gnt_who[1]), 64'(exp_a[1]));

      // 1010 held continuously.
      reset_dut();
      clear_logs();
      auto_drop = 0;
      apply_stimulus(1, 8'h90, 8'h91);
      apply_stimulus(3, 8'h92, 8'h91);
`ifdef CMP_ARB_FIXED_PRIO_EN
      exp_h = '{1, 1, 1};
`else
      exp_h = '{1, 3, 1};
`endif
      wait_dones(3);
      req = '0;
      auto_drop = 1;
      for (int i = 0; i < 3; i++) check_output($sformatf("held_order_%0d", i), 64'(gnt_who[i]), 64'(exp_h[i]));
      tick(); tick(); tick(); tick();

      // Reset while the transaction sits in WAIT.
      clear_logs();
      apply_stimulus(3, 8'h30, 8'h31);
      tick();
      tick();
      check_output("midop_in_wait_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      tick();
      check_output("midop_outputs_zero",
         64'({gnt, done, res_eq, res_gt, res_lt, res_err, busy, cmp_a, cmp_b}), 64'd0);
      rst = 1'b0;
      tick();
      check_output("midop_no_done", 64'(done_t.size()), 64'd0);
      clear_logs();
      c0 = cyc;
      apply_stimulus(3, 8'hA0, 8'h0A);
      apply_stimulus(0, 8'h0A, 8'h0A);
      wait_dones(2);
      check_output("after_rst_first_winner", 64'(gnt_who[0]), 64'd0);
      check_output("after_rst_second_winner", 64'(gnt_who[1]), 64'd3);
      check_output("after_rst_first_done", 64'(done_t[0] - c0), 64'd3);
      check_output("after_rst_req3_res", 64'(done_res[1]), 64'b0100);

      // Faulty comparator: eq and gt both raised.
      clear_logs();
      fault = 1;
      apply_stimulus(1, 8'h05, 8'h05);
      wait_dones(1);
      fault = 0;
      check_output("fault_res", 64'(done_res[0]), 64'b1101);

      // Latency-3 instance with faulty flags: done in cycle 5, busy falls in cycle 6.
      fault3 = 1;
      a3[0 +: W] = 8'h42;
      b3[0 +: W] = 8'h42;
      req3 = 4'b0001;
      for (int k = 0; k <= 6; k++) begin
         @(negedge clk);
         check_output($sformatf("lat3_cycle_%0d", k), 64'({gnt3, done3, busy3}),
            64'({(k == 1) ? 4'b0001 : 4'b0000, (k == 5) ? 4'b0001 : 4'b0000, (k >= 1 && k <= 5)}));
         if (k == 1) req3 = '0;
         if (k == 5) check_output("lat3_res", 64'({res_eq3, res_gt3, res_lt3, res_err3}), 64'b1101);
      end

      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
